// File: rtl/wb_stage_if.sv
// Memory-stage -> writeback-stage bus: one instruction's results plus HI/LO update request.
interface wb_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic [DW-1:0] pc_i;
  logic [DW-1:0] inst_i;
  logic [12:0]   wb_ctrl_i;
  logic [7:0]    mem_tag_i;
  logic [DW-1:0] rdata_i;
  logic [DW-1:0] aluout_i;
  logic [RW-1:0] db_dest_i;
  logic          is_mfhi_i;
  logic          is_mflo_i;
  logic [DW-1:0] cp0_rdata_i;
  logic          hi_we_i;
  logic          lo_we_i;
  logic [DW-1:0] hi_wdata_i;
  logic [DW-1:0] lo_wdata_i;
  logic          mem_stop_i;

  modport master (
    output pc_i, inst_i, wb_ctrl_i, mem_tag_i, rdata_i, aluout_i, db_dest_i,
           is_mfhi_i, is_mflo_i, cp0_rdata_i, hi_we_i, lo_we_i,
           hi_wdata_i, lo_wdata_i, mem_stop_i
  );

  modport slave (
    input  pc_i, inst_i, wb_ctrl_i, mem_tag_i, rdata_i, aluout_i, db_dest_i,
           is_mfhi_i, is_mflo_i, cp0_rdata_i, hi_we_i, lo_we_i,
           hi_wdata_i, lo_wdata_i, mem_stop_i
  );
endinterface

// File: rtl/wb_stage.sv
// MIPS writeback stage: MEM/WB pipeline register, write-data select, HI/LO ownership.
// Optional macro WB_TRACE_EN adds the debug_wb_* trace outputs.
module wb_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          resetn,
  wb_stage_if.slave     mem_if,
  output logic          rf_we_o,
  output logic [RW-1:0] rf_waddr_o,
  output logic [DW-1:0] rf_wdata_o,
  output logic          fwd_valid_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o,
  output logic [DW-1:0] wb_pc_o
`ifdef WB_TRACE_EN
  ,
  output logic [DW-1:0] debug_wb_pc,
  output logic [3:0]    debug_wb_rf_wen,
  output logic [RW-1:0] debug_wb_rf_wnum,
  output logic [DW-1:0] debug_wb_rf_wdata
`endif
);

  logic          regwrite_q, memtoreg_q, mfc0_q, mfhi_q, mflo_q, exc_q;
  logic [RW-1:0] dest_q;
  logic [DW-1:0] pc_q, rdata_q, aluout_q;
  logic [DW-1:0] hi_q, lo_q;
  logic          hi_wr, lo_wr;
  logic [DW-1:0] wdata_d;

  // The instruction word and the ignored control/tag bits are not needed past MEM.
  logic unused_bits;
  assign unused_bits = ^{mem_if.inst_i, mem_if.wb_ctrl_i[12:8], mem_if.wb_ctrl_i[6:2],
                         mem_if.mem_tag_i[7:1]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      mfc0_q     <= 1'b0;
      mfhi_q     <= 1'b0;
      mflo_q     <= 1'b0;
      exc_q      <= 1'b0;
      dest_q     <= '0;
      pc_q       <= '0;
      rdata_q    <= '0;
      aluout_q   <= '0;
    end else if (mem_if.mem_stop_i) begin
      // A stalled MEM inserts a bubble so the held instruction is written only once it leaves.
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      mfc0_q     <= 1'b0;
      mfhi_q     <= 1'b0;
      mflo_q     <= 1'b0;
      exc_q      <= 1'b0;
      dest_q     <= '0;
    end else begin
      regwrite_q <= mem_if.wb_ctrl_i[0];
      memtoreg_q <= mem_if.wb_ctrl_i[1];
      mfc0_q     <= mem_if.wb_ctrl_i[7];
      mfhi_q     <= mem_if.is_mfhi_i;
      mflo_q     <= mem_if.is_mflo_i;
      exc_q      <= mem_if.mem_tag_i[0];
      dest_q     <= mem_if.db_dest_i;
      pc_q       <= mem_if.pc_i;
      rdata_q    <= mem_if.rdata_i;
      aluout_q   <= mem_if.aluout_i;
    end
  end

  assign hi_wr = mem_if.hi_we_i & ~mem_if.mem_stop_i & ~mem_if.mem_tag_i[0];
  assign lo_wr = mem_if.lo_we_i & ~mem_if.mem_stop_i & ~mem_if.mem_tag_i[0];

  // An mfhi/mflo entering WB on the same edge sees the new value, since it reads hi_q/lo_q.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_wr) hi_q <= mem_if.hi_wdata_i;
      if (lo_wr) lo_q <= mem_if.lo_wdata_i;
    end
  end

  // NOTE: the default assignment first keeps this mux free of inferred latches.
  always_comb begin
    wdata_d = aluout_q;
    if (mfhi_q)        wdata_d = hi_q;
    else if (mflo_q)   wdata_d = lo_q;
    else if (mfc0_q)   wdata_d = mem_if.cp0_rdata_i;
    else if (memtoreg_q) wdata_d = rdata_q;
  end

  assign rf_we_o     = regwrite_q & ~exc_q & (dest_q != '0);
  assign rf_waddr_o  = dest_q;
  assign rf_wdata_o  = wdata_d;
  assign fwd_valid_o = rf_we_o & (rf_waddr_o != '0);
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign wb_pc_o     = pc_q;

`ifdef WB_TRACE_EN
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = {4{rf_we_o}};
  assign debug_wb_rf_wnum  = dest_q;
  assign debug_wb_rf_wdata = wdata_d;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table plus stall and async-reset sequences.
module tb_wb_stage;

  logic        clk;
  logic        resetn;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [31:0] hi, lo, wb_pc;
`ifdef WB_TRACE_EN
  logic [31:0] dbg_pc;
  logic [3:0]  dbg_wen;
  logic [4:0]  dbg_wnum;
  logic [31:0] dbg_wdata;
`endif

  int checks   = 0;
  int failures = 0;

  wb_stage_if #(.DW(32), .RW(5)) mem_if ();

  wb_stage #(.DW(32), .RW(5)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .mem_if     (mem_if.slave),
    .rf_we_o    (rf_we),
    .rf_waddr_o (rf_waddr),
    .rf_wdata_o (rf_wdata),
    .fwd_valid_o(fwd_valid),
    .hi_o       (hi),
    .lo_o       (lo),
    .wb_pc_o    (wb_pc)
`ifdef WB_TRACE_EN
    ,
    .debug_wb_pc      (dbg_pc),
    .debug_wb_rf_wen  (dbg_wen),
    .debug_wb_rf_wnum (dbg_wnum),
    .debug_wb_rf_wdata(dbg_wdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] ctrl;
    logic [7:0]  tag;
    logic [4:0]  dest;
    logic [31:0] rdata, alu, cp0;
    logic        mfhi, mflo, hi_we, lo_we;
    logic [31:0] hi_wd, lo_wd;
    logic        stop;
    logic [31:0] pc;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        chk_data;
    logic [31:0] exp_hi, exp_lo, exp_pc;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic drive_idle();
    mem_if.pc_i        = '0;
    mem_if.inst_i      = '0;
    mem_if.wb_ctrl_i   = '0;
    mem_if.mem_tag_i   = '0;
    mem_if.rdata_i     = '0;
    mem_if.aluout_i    = '0;
    mem_if.db_dest_i   = '0;
    mem_if.is_mfhi_i   = 1'b0;
    mem_if.is_mflo_i   = 1'b0;
    mem_if.cp0_rdata_i = '0;
    mem_if.hi_we_i     = 1'b0;
    mem_if.lo_we_i     = 1'b0;
    mem_if.hi_wdata_i  = '0;
    mem_if.lo_wdata_i  = '0;
    mem_if.mem_stop_i  = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    mem_if.pc_i        = v.pc;
    mem_if.inst_i      = 32'h0000_0000;
    mem_if.wb_ctrl_i   = v.ctrl;
    mem_if.mem_tag_i   = v.tag;
    mem_if.rdata_i     = v.rdata;
    mem_if.aluout_i    = v.alu;
    mem_if.db_dest_i   = v.dest;
    mem_if.is_mfhi_i   = v.mfhi;
    mem_if.is_mflo_i   = v.mflo;
    mem_if.cp0_rdata_i = v.cp0;
    mem_if.hi_we_i     = v.hi_we;
    mem_if.lo_we_i     = v.lo_we;
    mem_if.hi_wdata_i  = v.hi_wd;
    mem_if.lo_wdata_i  = v.lo_wd;
    mem_if.mem_stop_i  = v.stop;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_trace(input string tag);
`ifdef WB_TRACE_EN
    check({tag, ".dbg_pc"},    dbg_pc,           wb_pc);
    check({tag, ".dbg_wen"},   {28'd0, dbg_wen}, {28'd0, {4{rf_we}}});
    check({tag, ".dbg_wnum"},  {27'd0, dbg_wnum}, {27'd0, rf_waddr});
    check({tag, ".dbg_wdata"}, dbg_wdata,        rf_wdata);
`else
    if (tag.len() == 0) $display("empty trace tag");
`endif
  endtask

  initial begin
    // Fields: ctrl,tag,dest,rdata,alu,cp0,mfhi,mflo,hi_we,lo_we,hi_wd,lo_wd,stop,pc | we,addr,data,chk_data,hi,lo,pc
    vecs[0]  = '{13'h003,8'h00,5'd8, 32'hDEADBEEF,32'h100,32'h0,0,0,0,0,32'h0,32'h0,0,32'h1000,
                 1,5'd8, 32'hDEADBEEF,1,32'h0,32'h0,32'h1000};
    vecs[1]  = '{13'h001,8'h00,5'd7, 32'hAAAA,32'h55,32'h0,0,0,0,0,32'h0,32'h0,0,32'h1004,
                 1,5'd7, 32'h55,1,32'h0,32'h0,32'h1004};
    vecs[2]  = '{13'h001,8'h00,5'd0, 32'h0,32'h77,32'h0,0,0,0,0,32'h0,32'h0,0,32'h1008,
                 0,5'd0, 32'h77,1,32'h0,32'h0,32'h1008};
    vecs[3]  = '{13'h001,8'h01,5'd5, 32'h0,32'h99,32'h0,0,0,0,0,32'h0,32'h0,0,32'h100C,
                 0,5'd5, 32'h99,1,32'h0,32'h0,32'h100C};
    vecs[4]  = '{13'h000,8'h00,5'd0, 32'h0,32'h0,32'h0,0,0,1,0,32'h12345678,32'h0,0,32'h1010,
                 0,5'd0, 32'h0,1,32'h12345678,32'h0,32'h1010};
    vecs[5]  = '{13'h001,8'h00,5'd3, 32'h0,32'h0,32'h0,1,0,0,0,32'h0,32'h0,0,32'h1014,
                 1,5'd3, 32'h12345678,1,32'h12345678,32'h0,32'h1014};
    vecs[6]  = '{13'h000,8'h01,5'd0, 32'h0,32'h0,32'h0,0,0,1,0,32'hAAAA5555,32'h0,0,32'h1018,
                 0,5'd0, 32'h0,1,32'h12345678,32'h0,32'h1018};
    vecs[7]  = '{13'h001,8'h00,5'd3, 32'h0,32'h0,32'h0,1,0,0,0,32'h0,32'h0,0,32'h101C,
                 1,5'd3, 32'h12345678,1,32'h12345678,32'h0,32'h101C};
    vecs[8]  = '{13'h001,8'h00,5'd4, 32'h0,32'h0,32'h0,0,1,1,1,32'h11111111,32'h22222222,0,32'h1020,
                 1,5'd4, 32'h22222222,1,32'h11111111,32'h22222222,32'h1020};
    vecs[9]  = '{13'h081,8'h00,5'd6, 32'hDDDD,32'h1,32'hC0C0C0C0,0,0,0,0,32'h0,32'h0,0,32'h1024,
                 1,5'd6, 32'hC0C0C0C0,1,32'h11111111,32'h22222222,32'h1024};
    vecs[10] = '{13'h083,8'h00,5'd10,32'hDD,32'h2,32'hC0,1,0,0,0,32'h0,32'h0,0,32'h1028,
                 1,5'd10,32'h11111111,1,32'h11111111,32'h22222222,32'h1028};
    vecs[11] = '{13'h083,8'h00,5'd11,32'hDD,32'h3,32'hC0,0,1,0,0,32'h0,32'h0,0,32'h102C,
                 1,5'd11,32'h22222222,1,32'h11111111,32'h22222222,32'h102C};
    vecs[12] = '{13'h083,8'h00,5'd12,32'hDD,32'h4,32'h0BADF00D,0,0,0,0,32'h0,32'h0,0,32'h1030,
                 1,5'd12,32'h0BADF00D,1,32'h11111111,32'h22222222,32'h1030};
    vecs[13] = '{13'h003,8'h00,5'd13,32'hFEEDFACE,32'h5,32'hC0,0,0,0,0,32'h0,32'h0,0,32'h1034,
                 1,5'd13,32'hFEEDFACE,1,32'h11111111,32'h22222222,32'h1034};
    vecs[14] = '{13'h1F01,8'hFE,5'd14,32'h0,32'h1234,32'h0,0,0,0,0,32'h0,32'h0,0,32'h1038,
                 1,5'd14,32'h1234,1,32'h11111111,32'h22222222,32'h1038};
    vecs[15] = '{13'h001,8'h00,5'd15,32'h0,32'h5555,32'h0,0,0,0,1,32'h0,32'h33333333,1,32'h103C,
                 0,5'd0, 32'h0,0,32'h11111111,32'h22222222,32'h1038};

    resetn = 1'b0;
    drive_idle();
    #12;
    check("reset.rf_we",    {31'd0, rf_we},     32'd0);
    check("reset.waddr",    {27'd0, rf_waddr},  32'd0);
    check("reset.wdata",    rf_wdata,           32'd0);
    check("reset.fwd",      {31'd0, fwd_valid}, 32'd0);
    check("reset.hi",       hi,                 32'd0);
    check("reset.lo",       lo,                 32'd0);
    check("reset.pc",       wb_pc,              32'd0);
    check_trace("reset");
    resetn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive_vec(vecs[i]);
      step();
      check($sformatf("v%0d.rf_we", i), {31'd0, rf_we},     {31'd0, vecs[i].exp_we});
      check($sformatf("v%0d.fwd", i),   {31'd0, fwd_valid}, {31'd0, vecs[i].exp_we});
      check($sformatf("v%0d.waddr", i), {27'd0, rf_waddr},  {27'd0, vecs[i].exp_addr});
      if (vecs[i].chk_data)
        check($sformatf("v%0d.wdata", i), rf_wdata, vecs[i].exp_data);
      check($sformatf("v%0d.hi", i), hi,    vecs[i].exp_hi);
      check($sformatf("v%0d.lo", i), lo,    vecs[i].exp_lo);
      check($sformatf("v%0d.pc", i), wb_pc, vecs[i].exp_pc);
      check_trace($sformatf("v%0d", i));
    end

    // Held instruction with a pending HI write: nothing may retire until the stall lifts.
    drive_idle();
    mem_if.wb_ctrl_i  = 13'h001;
    mem_if.db_dest_i  = 5'd9;
    mem_if.aluout_i   = 32'h909;
    mem_if.hi_we_i    = 1'b1;
    mem_if.hi_wdata_i = 32'hCAFE0001;
    mem_if.pc_i       = 32'h2000;
    mem_if.mem_stop_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("stall%0d.rf_we", c), {31'd0, rf_we}, 32'd0);
      check($sformatf("stall%0d.hi", c),    hi,             32'h11111111);
      check($sformatf("stall%0d.pc", c),    wb_pc,          32'h1038);
    end
    mem_if.mem_stop_i = 1'b0;
    step();
    check("release.rf_we", {31'd0, rf_we},    32'd1);
    check("release.waddr", {27'd0, rf_waddr}, 32'd9);
    check("release.wdata", rf_wdata,          32'h909);
    check("release.hi",    hi,                32'hCAFE0001);
    check("release.pc",    wb_pc,             32'h2000);
    drive_idle();
    step();
    check("after_release.rf_we", {31'd0, rf_we}, 32'd0);
    check("after_release.hi",    hi,             32'hCAFE0001);

    // Asynchronous reset in the middle of a valid write.
    mem_if.wb_ctrl_i = 13'h001;
    mem_if.db_dest_i = 5'd20;
    mem_if.aluout_i  = 32'hABCD;
    step();
    check("prereset.rf_we", {31'd0, rf_we}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("midreset.rf_we", {31'd0, rf_we},     32'd0);
    check("midreset.fwd",   {31'd0, fwd_valid}, 32'd0);
    check("midreset.waddr", {27'd0, rf_waddr},  32'd0);
    check("midreset.wdata", rf_wdata,           32'd0);
    check("midreset.hi",    hi,                 32'd0);
    check("midreset.lo",    lo,                 32'd0);
    check("midreset.pc",    wb_pc,              32'd0);
    check_trace("midreset");
    drive_idle();
    #2;
    resetn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      check($sformatf("postreset%0d.rf_we", c), {31'd0, rf_we}, 32'd0);
      check($sformatf("postreset%0d.hi", c),    hi,             32'd0);
      check($sformatf("postreset%0d.lo", c),    lo,             32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
